// File: rtl/qnigma_pkg.sv
// qnigma shared types and constants.
// Used by the IPv6 transmit framer and its header selector.
package qnigma_pkg;

  localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;
  localparam int ETH_HDR_LEN   = 14;
  localparam int IPV6_HDR_LEN  = 40;
  localparam int HDR_LEN       = ETH_HDR_LEN + IPV6_HDR_LEN;
  localparam int MIN_FRAME_DEF = 60;

  typedef logic [47:0]  mac_t;
  typedef logic [127:0] ip_t;

  typedef enum logic [1:0] {
    PROTO_ICMP,
    PROTO_TCP,
    PROTO_UDP
  } proto_t;

  typedef struct packed {
    mac_t dst;
    mac_t src;
  } meta_mac_t;

  typedef struct packed {
    ip_t         src;
    ip_t         dst;
    logic [7:0]  pro;
    logic [15:0] len;
    logic [7:0]  hop;
  } meta_ip_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_L4,
    ST_PAD,
    ST_IFG
  } tx_state_t;

endpackage

// File: rtl/qnigma_ip_tx_hdr.sv
// Ethernet II + IPv6 header byte selector.
// Pure combinational lookup of header byte idx from latched meta.
module qnigma_ip_tx_hdr
  import qnigma_pkg::*;
(
  input  meta_mac_t  mac,
  input  meta_ip_t   ip,
  input  logic [5:0] idx,
  output logic [7:0] hdr_byte
);

  logic [HDR_LEN*8-1:0] hdr_vec;

  // flatten header in wire order, pick byte idx (MSB first)
  always_comb begin
    hdr_vec = {mac.dst, mac.src,
               ETH_TYPE_IPV6,
               32'h6000_0000,
               ip.len, ip.pro, ip.hop,
               ip.src, ip.dst};
    hdr_byte = 8'h00;
    if (idx < 6'(HDR_LEN))
      hdr_byte = hdr_vec[
        9'(6'(HDR_LEN - 1) - idx) * 9'd8 +: 8];
  end

endmodule

// File: rtl/qnigma_ip_tx.sv
// IPv6 transmit framer: header, L4 forward, pad, IFG.
// Output byte stream is registered; one byte per valid cycle.
module qnigma_ip_tx
  import qnigma_pkg::*;
#(
  parameter int MIN_FRAME = MIN_FRAME_DEF,
  parameter int IFG_CYC   = 12,
  parameter int L4_TO     = 1023
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  proto_t     tx_proto,
  input  meta_mac_t  meta_mac,
  input  meta_ip_t   meta_ip,
  output logic       tx_busy,
  output logic       tx_done,
  output proto_t     l4_proto,
  output logic       l4_req,
  input  logic       l4_val,
  input  logic [7:0] l4_dat,
  output logic [7:0] dat_out,
  output logic       val_out,
  output logic       sof_out,
  output logic       eof_out,
  output logic       err_out
);

  tx_state_t   state_q, state_d;
  logic [15:0] idx_q, idx_d;
  logic [15:0] l4c_q, l4c_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] to_q, to_d;
  meta_mac_t   mac_q, mac_d;
  meta_ip_t    ip_q, ip_d;
  proto_t      proto_q, proto_d;
  logic [7:0]  dat_q, dat_d;
  logic        val_q, val_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;

  logic [7:0]  hdr_byte;
  logic [15:0] fcnt_inc;
  logic        pad_need;
  logic        ifg_end;

  qnigma_ip_tx_hdr u_hdr (
    .mac      (mac_q),
    .ip       (ip_q),
    .idx      (idx_q[5:0]),
    .hdr_byte (hdr_byte)
  );

  assign fcnt_inc = (fcnt_q == 16'hFFFF)
                  ? fcnt_q : fcnt_q + 16'd1;
  assign pad_need = (17'(ip_q.len) + 17'(HDR_LEN))
                  < 17'(MIN_FRAME);
  assign ifg_end  = (state_q == ST_IFG)
                 && (idx_q == 16'(IFG_CYC));

  // state, counters, latched meta and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      l4c_q   <= '0;
      fcnt_q  <= '0;
      to_q    <= '0;
      mac_q   <= '0;
      ip_q    <= '0;
      proto_q <= PROTO_ICMP;
      dat_q   <= '0;
      val_q   <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      l4c_q   <= l4c_d;
      fcnt_q  <= fcnt_d;
      to_q    <= to_d;
      mac_q   <= mac_d;
      ip_q    <= ip_d;
      proto_q <= proto_d;
      dat_q   <= dat_d;
      val_q   <= val_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      err_q   <= err_d;
    end
  end

  // next state and next output byte
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    l4c_d   = l4c_q;
    fcnt_d  = fcnt_q;
    to_d    = to_q;
    mac_d   = mac_q;
    ip_d    = ip_q;
    proto_d = proto_q;
    dat_d   = 8'h00;
    val_d   = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (send) begin
          mac_d   = meta_mac;
          ip_d    = meta_ip;
          proto_d = tx_proto;
          idx_d   = '0;
          l4c_d   = '0;
          fcnt_d  = '0;
          to_d    = '0;
          state_d = ST_HDR;
        end
      end
      ST_HDR: begin
        dat_d  = hdr_byte;
        val_d  = 1'b1;
        sof_d  = (idx_q == 16'd0);
        fcnt_d = fcnt_inc;
        idx_d  = idx_q + 16'd1;
        if (idx_q == 16'(HDR_LEN - 1)) begin
          idx_d = '0;
          if (ip_q.len != 16'd0)
            state_d = ST_L4;
          else if (pad_need)
            state_d = ST_PAD;
          else begin
            eof_d   = 1'b1;
            state_d = ST_IFG;
          end
        end
      end
      ST_L4: begin
        if (l4_val) begin
          dat_d  = l4_dat;
          val_d  = 1'b1;
          fcnt_d = fcnt_inc;
          l4c_d  = l4c_q + 16'd1;
          to_d   = '0;
          if (l4c_q + 16'd1 == ip_q.len) begin
            if (pad_need)
              state_d = ST_PAD;
            else begin
              eof_d   = 1'b1;
              state_d = ST_IFG;
            end
          end
        end else if (to_q == 16'(L4_TO - 1)) begin
          val_d   = 1'b1;
          eof_d   = 1'b1;
          err_d   = 1'b1;
          fcnt_d  = fcnt_inc;
          state_d = ST_IFG;
        end else begin
          to_d = to_q + 16'd1;
        end
      end
      ST_PAD: begin
        val_d  = 1'b1;
        fcnt_d = fcnt_inc;
        if (fcnt_inc >= 16'(MIN_FRAME)) begin
          eof_d   = 1'b1;
          state_d = ST_IFG;
        end
      end
      ST_IFG: begin
        if (ifg_end)
          state_d = ST_IDLE;
        else if (!val_q)
          idx_d = idx_q + 16'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    tx_busy = (state_q != ST_IDLE);
    tx_done = ifg_end;
    l4_req  = (state_q == ST_L4);
  end

  assign l4_proto = proto_q;
  assign dat_out  = dat_q;
  assign val_out  = val_q;
  assign sof_out  = sof_q;
  assign eof_out  = eof_q;
  assign err_out  = err_q;

endmodule

// File: tb/tb_qnigma_ip_tx.sv
// Directed bench for qnigma_ip_tx.
// Table of frames plus reset-abort sequence.
module tb_qnigma_ip_tx;
  import qnigma_pkg::*;

  localparam int MIN_F  = 60;
  localparam int IFG_C  = 12;
  localparam int TO_C   = 1023;

  logic       clk;
  logic       rst;
  logic       send;
  proto_t     tx_proto;
  meta_mac_t  drv_mac;
  meta_ip_t   drv_ip;
  logic       tx_busy;
  logic       tx_done;
  proto_t     l4_proto;
  logic       l4_req;
  logic       l4_val;
  logic [7:0] l4_dat;
  logic [7:0] dat_out;
  logic       val_out;
  logic       sof_out;
  logic       eof_out;
  logic       err_out;

  qnigma_ip_tx #(
    .MIN_FRAME (MIN_F),
    .IFG_CYC   (IFG_C),
    .L4_TO     (TO_C)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .send     (send),
    .tx_proto (tx_proto),
    .meta_mac (drv_mac),
    .meta_ip  (drv_ip),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done),
    .l4_proto (l4_proto),
    .l4_req   (l4_req),
    .l4_val   (l4_val),
    .l4_dat   (l4_dat),
    .dat_out  (dat_out),
    .val_out  (val_out),
    .sof_out  (sof_out),
    .eof_out  (eof_out),
    .err_out  (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string  name;
    proto_t proto;
    int     len;
    int     gap;
    int     stall;
    int     hold;
    bit     resend;
    bit     junk;
    int     exp_n;
    int     exp_err;
  } vec_t;

  vec_t tbl[7];

  int checks;
  int errors;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         oc_q[$];
  int         drv_q[$];

  task automatic chk(input string nm,
                     input int act,
                     input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d",
               nm, act, req);
    end
  endtask

  function automatic logic [7:0] l4_byte(input int i);
    return 8'((i * 7 + 17) & 255);
  endfunction

  function automatic meta_mac_t mk_mac();
    meta_mac_t m;
    m.dst = 48'h3333_FF00_0001;
    m.src = 48'h0200_0000_00AA;
    return m;
  endfunction

  function automatic meta_ip_t mk_ip(input vec_t v);
    meta_ip_t m;
    m.src = 128'hFE80_0000_0000_0000_0000_0000_0000_0001;
    m.dst = 128'hFF02_0000_0000_0000_0000_0001_FF00_0001;
    m.len = 16'(v.len);
    m.hop = 8'd255;
    case (v.proto)
      PROTO_TCP: m.pro = 8'd6;
      PROTO_UDP: m.pro = 8'd17;
      default:   m.pro = 8'd58;
    endcase
    return m;
  endfunction

  task automatic build_exp(input vec_t v);
    meta_mac_t mm;
    meta_ip_t  mi;
    int        nl4;
    bit        ab;
    mm = mk_mac();
    mi = mk_ip(v);
    exp_q.delete();
    for (int i = 0; i < 6; i++)
      exp_q.push_back(mm.dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++)
      exp_q.push_back(mm.src[47-8*i -: 8]);
    exp_q.push_back(8'h86);
    exp_q.push_back(8'hDD);
    exp_q.push_back(8'h60);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(mi.len[15:8]);
    exp_q.push_back(mi.len[7:0]);
    exp_q.push_back(mi.pro);
    exp_q.push_back(mi.hop);
    for (int i = 0; i < 16; i++)
      exp_q.push_back(mi.src[127-8*i -: 8]);
    for (int i = 0; i < 16; i++)
      exp_q.push_back(mi.dst[127-8*i -: 8]);
    ab  = (v.stall != 0) && (v.stall < v.len);
    nl4 = ab ? v.stall : v.len;
    for (int i = 0; i < nl4; i++)
      exp_q.push_back(l4_byte(i));
    if (ab)
      exp_q.push_back(8'h00);
    else
      while (exp_q.size() < MIN_F)
        exp_q.push_back(8'h00);
  endtask

  task automatic run_vec(input vec_t v);
    int c, first, sofs, sof_idx, eofs, eof_idx;
    int eof_cyc, done_cyc, err_v, err_stray;
    int nobusy, l4req_n, lcyc, nsent;
    int mism, tmis, quiet, prot, nl4;
    bit fin;
    build_exp(v);
    got_q.delete();
    oc_q.delete();
    drv_q.delete();
    first = -1; sofs = 0; sof_idx = -1;
    eofs = 0; eof_idx = -1; eof_cyc = 0;
    done_cyc = -1; err_v = -1; err_stray = 0;
    nobusy = 0; l4req_n = 0; lcyc = 0;
    nsent = 0; prot = -1; fin = 1'b0;
    drv_mac  = mk_mac();
    drv_ip   = mk_ip(v);
    tx_proto = v.proto;
    @(posedge clk); #1;
    send = 1'b1;
    c = 0;
    while (!fin && c < 3000) begin
      @(posedge clk); #1;
      c++;
      if (c == v.hold) send = 1'b0;
      if (v.resend && c == 40) send = 1'b1;
      if (v.resend && c == 41) send = 1'b0;
      if (!tx_busy) nobusy++;
      if (l4_req) l4req_n++;
      if (c == 5) prot = int'(l4_proto);
      if (val_out) begin
        if (first < 0) first = c;
        if (sof_out) begin
          sofs++;
          sof_idx = got_q.size();
        end
        if (eof_out) begin
          eofs++;
          eof_idx = got_q.size();
          eof_cyc = c;
          err_v   = int'(err_out);
        end else if (err_out) begin
          err_stray++;
        end
        got_q.push_back(dat_out);
        oc_q.push_back(c);
      end
      if (tx_done) begin
        done_cyc = c;
        fin = 1'b1;
      end
      l4_val = 1'b0;
      l4_dat = 8'h00;
      if (l4_req) begin
        if ((lcyc % v.gap) == 0 &&
            !(v.stall != 0 && nsent >= v.stall)) begin
          l4_val = 1'b1;
          l4_dat = l4_byte(nsent);
          drv_q.push_back(c + 1);
          nsent++;
        end
        lcyc++;
      end else if (v.junk) begin
        l4_val = 1'b1;
        l4_dat = 8'hEE;
      end
    end
    l4_val = 1'b0;
    send   = 1'b0;
    chk({v.name, ":done_seen"}, int'(fin), 1);
    chk({v.name, ":nbytes"}, got_q.size(), v.exp_n);
    mism = 0;
    for (int i = 0; i < got_q.size(); i++)
      if (i >= exp_q.size() || got_q[i] != exp_q[i])
        mism++;
    chk({v.name, ":byte_errs"}, mism, 0);
    chk({v.name, ":sof_cnt"}, sofs, 1);
    chk({v.name, ":sof_idx"}, sof_idx, 0);
    chk({v.name, ":eof_cnt"}, eofs, 1);
    chk({v.name, ":eof_idx"}, eof_idx, v.exp_n - 1);
    chk({v.name, ":err"}, err_v, v.exp_err);
    chk({v.name, ":err_stray"}, err_stray, 0);
    chk({v.name, ":first_lat"}, first, 2);
    chk({v.name, ":done_gap"}, done_cyc - eof_cyc,
        IFG_C + 1);
    chk({v.name, ":busy_hole"}, nobusy, 0);
    chk({v.name, ":l4_proto"}, prot, int'(v.proto));
    nl4 = (v.stall != 0 && v.stall < v.len)
        ? v.stall : v.len;
    chk({v.name, ":l4_drv"}, drv_q.size(), nl4);
    tmis = 0;
    for (int k = 0; k < drv_q.size(); k++)
      if (HDR_LEN + k >= oc_q.size() ||
          oc_q[HDR_LEN + k] != drv_q[k])
        tmis++;
    chk({v.name, ":l4_timing"}, tmis, 0);
    if (v.len == 0)
      chk({v.name, ":l4_req_cyc"}, l4req_n, 0);
    if (v.stall != 0 &&
        oc_q.size() >= HDR_LEN + v.stall)
      chk({v.name, ":stall_cyc"},
          eof_cyc - oc_q[HDR_LEN + v.stall - 1], TO_C);
    if (v.len == 32 && got_q.size() > 19) begin
      chk({v.name, ":b12"}, int'(got_q[12]), 'h86);
      chk({v.name, ":b13"}, int'(got_q[13]), 'hDD);
      chk({v.name, ":b18"}, int'(got_q[18]), 'h00);
      chk({v.name, ":b19"}, int'(got_q[19]), 'h20);
    end
    @(posedge clk); #1;
    chk({v.name, ":busy_after"}, int'(tx_busy), 0);
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      if (val_out || tx_busy || tx_done) quiet++;
      @(posedge clk); #1;
    end
    chk({v.name, ":quiet"}, quiet, 0);
  endtask

  task automatic rst_mid_frame();
    vec_t v;
    int   c, nb, bad;
    v = tbl[0];
    drv_mac  = mk_mac();
    drv_ip   = mk_ip(v);
    tx_proto = v.proto;
    @(posedge clk); #1;
    send = 1'b1;
    c = 0;
    nb = 0;
    while (nb < 31 && c < 200) begin
      @(posedge clk); #1;
      c++;
      send = 1'b0;
      if (val_out) nb++;
    end
    chk("rst:reach_b30", nb, 31);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst:val_out", int'(val_out), 0);
    chk("rst:tx_busy", int'(tx_busy), 0);
    chk("rst:eof_out", int'(eof_out), 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (val_out || tx_done || tx_busy) bad++;
      @(posedge clk); #1;
    end
    chk("rst:silent", bad, 0);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    send     = 1'b0;
    tx_proto = PROTO_ICMP;
    drv_mac  = '0;
    drv_ip   = '0;
    l4_val   = 1'b0;
    l4_dat   = 8'h00;

    tbl[0] = '{"icmp_ns", PROTO_ICMP, 32, 1, 0,
               1, 1'b0, 1'b0, 86, 0};
    tbl[1] = '{"udp_short", PROTO_UDP, 2, 1, 0,
               1, 1'b0, 1'b1, 60, 0};
    tbl[2] = '{"tcp_gap", PROTO_TCP, 20, 3, 0,
               1, 1'b0, 1'b0, 74, 0};
    tbl[3] = '{"udp_stall", PROTO_UDP, 10, 1, 5,
               1, 1'b0, 1'b0, 60, 1};
    tbl[4] = '{"b2b", PROTO_ICMP, 8, 1, 0,
               2, 1'b1, 1'b0, 62, 0};
    tbl[5] = '{"len0", PROTO_UDP, 0, 1, 0,
               1, 1'b0, 1'b0, 60, 0};
    tbl[6] = '{"exact60", PROTO_TCP, 6, 1, 0,
               1, 1'b0, 1'b0, 60, 0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset:tx_busy", int'(tx_busy), 0);
    chk("reset:tx_done", int'(tx_done), 0);
    chk("reset:l4_req", int'(l4_req), 0);
    chk("reset:val_out", int'(val_out), 0);
    chk("reset:sof_out", int'(sof_out), 0);
    chk("reset:eof_out", int'(eof_out), 0);
    chk("reset:err_out", int'(err_out), 0);
    chk("reset:dat_out", int'(dat_out), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++)
      run_vec(tbl[i]);

    rst_mid_frame();
    run_vec(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
